deck_shuffler: RTL and testbench
================================

Name: deck_shuffler

Overview:
Upstream stage of the memory-game controller. On request, it builds a 16-card deck of 8 pairs and shuffles it in place with a hardware Fisher-Yates pass driven by a free-running LFSR. When the shuffle finishes it pulses done; the game FSM consumes this as its cartas_revueltas input. It then serves two registered read ports, which the game FSM uses to fetch carta_1 and carta_2 for pair comparison.

Parameters:
N_CARDS, 16, number of cards in the deck. Fixed at 16; the widths below depend on it.
SEED, 16'hACE1, LFSR reset value. Must be non-zero.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  shuffle request; sampled only in IDLE
rd_addr_a  in  4  card slot index, port A
rd_addr_b  in  4  card slot index, port B
rd_data_a  out  3  pair id at slot rd_addr_a, registered
rd_data_b  out  3  pair id at slot rd_addr_b, registered
busy  out  1  high from INIT through SWAP, inclusive
done  out  1  one-cycle pulse when the shuffle is complete
ready  out  1  high in IDLE once at least one shuffle has completed since reset

Behaviour:
- Storage: deck[0..15], 3 bits each, held in flops.
- Reset values:
  - deck[k] = k>>1 (sorted order)
  - lfsr = SEED, state = IDLE
  - rd_data_a = rd_data_b = 0
  - busy = 0, done = 0, ready = 0
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), shifting left.
  - Advances every cycle in every state, so the shuffle result depends on when start arrives.
  - r = lfsr[3:0] is the value sampled in the current cycle.
- FSM states: IDLE, INIT, SWAP, DONE.
  - IDLE: if start=1, go to INIT. Otherwise stay.
  - INIT (1 cycle):
    - deck[k] <= k>>1 for all k
    - i <= 15
    - go to SWAP
  - SWAP (1 cycle per i):
    - j = (r * (i+1)) >> 4, computed on an 8-bit product, so 0 <= j <= i.
    - Swap deck[i] and deck[j] in the same cycle; j==i is a no-op.
    - If i==1, go to DONE. Otherwise i <= i-1.
  - DONE (1 cycle): done=1, ready is set, go to IDLE.
- Latency: start sampled high at edge 0 gives INIT at cycle 1, SWAP at cycles 2..16 (15 swaps), done=1 during cycle 17.
- busy is high during cycles 1..16 and low in DONE. busy and done are never high together.
- start is ignored in INIT, SWAP and DONE; no queuing. A start held high re-triggers once the FSM is back in IDLE.
- Reads:
  - rd_data_x <= deck[rd_addr_x] at every edge (1-cycle latency), in every state.
  - Data read while busy=1 is a partial shuffle and is not meaningful; the consumer waits for done.
  - A read in the same cycle as a swap returns the pre-swap value.
  - Equal addresses on A and B return the same data.
- ready: clears when a new shuffle starts (INIT), sets again in DONE.
- Reset mid-shuffle: immediately IDLE, deck back to sorted order, busy=0, ready=0, no done pulse.
- Invariant: after every DONE, each pair id 0..7 occupies exactly two slots.

Decomposition:
- Package memory_pkg:
  - N_CARDS = 16, N_PAIRS = 8
  - typedef card_idx_t = logic[3:0]
  - typedef pair_id_t = logic[2:0]
  - LFSR tap constant
  - shuffle state enum {IDLE, INIT, SWAP, DONE}
- Sub-module lfsr16 (clk, rst, SEED parameter, q[15:0]): free-running, no enable. Reused later for the random-card pick on timeout.

Test Plan:
- Reset: assert rst mid-run, then release -> busy=0, done=0, ready=0; reading addresses 0..15 yields 0,0,1,1,...,7,7.
- Single shuffle: start pulse at cycle 0 -> busy high for cycles 1..16; done high only in cycle 17; ready=1 from cycle 18.
- Permutation check: after each of 50 shuffles started at random offsets -> histogram of the 16 reads is exactly two of each id 0..7.
- Golden model: start at 10 cycles after reset with SEED=16'hACE1 -> deck matches the reference-model Fisher-Yates using the same LFSR and j formula, slot for slot. Starting at 11 cycles gives a different deck.
- start asserted during SWAP (cycle 8) -> ignored; done still occurs at cycle 17 and only once. start held high continuously -> next INIT follows one cycle after DONE.
- Reset at cycle 9 of a shuffle -> no done pulse, sorted deck, ready=0. A new start afterwards completes normally in 17 cycles.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and constants for the memory-game deck logic.
package memory_pkg;

   localparam int          N_CARDS   = 16;
   localparam int          N_PAIRS   = 8;
   // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef logic [3:0] card_idx_t;
   typedef logic [2:0] pair_id_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      SWAP = 2'd2,
      DONE = 2'd3
   } shuffle_state_t;

   function automatic pair_id_t sorted_id(input card_idx_t k);
      return k[3:1];
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left, no enable.
module lfsr16
   import memory_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] o_q
);

   logic [15:0] r_q;
   logic        w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);
   assign o_q  = r_q;

   // Shift register advances on every edge outside reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= SEED;
      end else begin
         r_q <= {r_q[14:0], w_fb};
      end
   end

endmodule

// File: rtl/deck_shuffler.sv
// Builds a 16-card deck of 8 pairs, Fisher-Yates shuffles it from a free-running
// LFSR, then serves two registered read ports to the game FSM.
module deck_shuffler #(
   parameter int          N_CARDS = 16,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [3:0] i_rd_addr_a,
   input  logic [3:0] i_rd_addr_b,
   output logic [2:0] o_rd_data_a,
   output logic [2:0] o_rd_data_b,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_ready
);

   import memory_pkg::*;

   logic [15:0]    w_lfsr;
   logic           w_lfsr_unused;
   logic [4:0]     w_i_plus1;
   logic [7:0]     w_prod;
   card_idx_t      w_j;

   shuffle_state_t r_state;
   card_idx_t      r_i;
   pair_id_t       r_deck [N_CARDS];
   pair_id_t       r_rd_data_a;
   pair_id_t       r_rd_data_b;
   logic           r_busy;
   logic           r_done;
   logic           r_ready;

   lfsr16 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .o_q (w_lfsr)
   );

   // Only the low nibble feeds the shuffle; the rest is reserved for other users.
   assign w_lfsr_unused = ^w_lfsr[15:4];

   // j = (r * (i+1)) >> 4 keeps the pick uniform-ish within 0..i.
   assign w_i_plus1 = {1'b0, r_i} + 5'd1;
   assign w_prod    = {4'd0, w_lfsr[3:0]} * {3'd0, w_i_plus1};
   assign w_j       = w_prod[7:4];

   assign o_rd_data_a = r_rd_data_a;
   assign o_rd_data_b = r_rd_data_b;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_ready     = r_ready;

   // Shuffle FSM: owns the deck, the swap index and the status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_i     <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b0;
         for (int k = 0; k < N_CARDS; k++) begin
            r_deck[k] <= sorted_id(card_idx_t'(k));
         end
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state <= INIT;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
               end else begin
                  r_state <= IDLE;
               end
            end
            INIT: begin
               for (int k = 0; k < N_CARDS; k++) begin
                  r_deck[k] <= sorted_id(card_idx_t'(k));
               end
               r_i     <= 4'd15;
               r_state <= SWAP;
            end
            SWAP: begin
               // When j == i both writes carry the same value.
               r_deck[r_i] <= r_deck[w_j];
               r_deck[w_j] <= r_deck[r_i];
               if (r_i == 4'd1) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_i <= r_i - 4'd1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Read ports sample the deck every edge, so a same-cycle swap reads old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data_a <= 3'd0;
         r_rd_data_b <= 3'd0;
      end else begin
         r_rd_data_a <= r_deck[i_rd_addr_a];
         r_rd_data_b <= r_deck[i_rd_addr_b];
      end
   end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: reset contents, shuffle timing, golden-model decks.
module tb_deck_shuffler;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] addr_a = 4'd0;
   logic [3:0] addr_b = 4'd0;
   logic [2:0] data_a, data_b;
   logic       busy, done, ready;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] ea;
      logic [2:0] eb;
   } vec_t;
   vec_t tbl [10];

   logic [2:0] buf_a [16];
   logic [2:0] buf_b [16];
   logic [2:0] mdl   [16];
   logic [2:0] d10   [16];

   deck_shuffler #(
      .N_CARDS (16),
      .SEED    (SEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_rd_addr_a (addr_a),
      .i_rd_addr_b (addr_b),
      .o_rd_data_a (data_a),
      .o_rd_data_b (data_b),
      .o_busy      (busy),
      .o_done      (done),
      .o_ready     (ready)
   );

   always #5 clk = ~clk;

   // Counts LFSR steps since the last reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Reference Fisher-Yates for a start raised while cyc == e.
   task automatic build_model(input int e);
      logic [15:0] l;
      logic [2:0]  t;
      int          r, j;
      l = SEED;
      for (int n = 0; n < e + 2; n++) l = step(l);
      for (int k = 0; k < 16; k++) mdl[k] = 3'(k / 2);
      for (int i = 15; i >= 1; i--) begin
         r = int'(l[3:0]);
         j = (r * (i + 1)) / 16;
         t = mdl[i]; mdl[i] = mdl[j]; mdl[j] = t;
         l = step(l);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_data_a", 32'(data_a), 32'd0);
      chk("rst_data_b", 32'(data_b), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic apply_table(input string tag);
      for (int v = 0; v < 10; v++) begin
         addr_a = tbl[v].a;
         addr_b = tbl[v].b;
         @(negedge clk);
         chk($sformatf("%s_a%0d", tag, v), 32'(data_a), 32'(tbl[v].ea));
         chk($sformatf("%s_b%0d", tag, v), 32'(data_b), 32'(tbl[v].eb));
      end
   endtask

   task automatic read_deck();
      for (int k = 0; k < 16; k++) begin
         addr_a = 4'(k);
         addr_b = 4'(15 - k);
         @(negedge clk);
         buf_a[k]      = data_a;
         buf_b[15 - k] = data_b;
      end
   endtask

   task automatic check_deck(input string tag);
      int cnt [8];
      for (int id = 0; id < 8; id++) cnt[id] = 0;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("%s_slot%0d_a", tag, k), 32'(buf_a[k]), 32'(mdl[k]));
         chk($sformatf("%s_slot%0d_b", tag, k), 32'(buf_b[k]), 32'(mdl[k]));
         cnt[buf_a[k]]++;
      end
      for (int id = 0; id < 8; id++)
         chk($sformatf("%s_hist%0d", tag, id), 32'(cnt[id]), 32'd2);
   endtask

   // Start pulse after `pre` idle cycles; optional stray start at cycle poke_k.
   task automatic shuffle_timed(input int pre, input int poke_k, output int e);
      repeat (pre) @(negedge clk);
      e = cyc;
      start = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         chk($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= 16));
         chk($sformatf("done_c%0d", k), 32'(done), 32'(k == 17));
         chk($sformatf("ready_c%0d", k), 32'(ready), 32'(k >= 18));
         start = (poke_k != 0 && k == poke_k) ? 1'b1 : 1'b0;
      end
   endtask

   initial begin
      int e;
      int ndone;
      int diff;
      tbl[0] = '{4'd0,  4'd15, 3'd0, 3'd7};
      tbl[1] = '{4'd1,  4'd14, 3'd0, 3'd7};
      tbl[2] = '{4'd2,  4'd13, 3'd1, 3'd6};
      tbl[3] = '{4'd3,  4'd12, 3'd1, 3'd6};
      tbl[4] = '{4'd4,  4'd11, 3'd2, 3'd5};
      tbl[5] = '{4'd5,  4'd10, 3'd2, 3'd5};
      tbl[6] = '{4'd6,  4'd9,  3'd3, 3'd4};
      tbl[7] = '{4'd7,  4'd8,  3'd3, 3'd4};
      tbl[8] = '{4'd9,  4'd9,  3'd4, 3'd4};
      tbl[9] = '{4'd15, 4'd0,  3'd7, 3'd0};

      repeat (3) @(negedge clk);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_done", 32'(done), 32'd0);
      chk("init_ready", 32'(ready), 32'd0);
      rst = 1'b0;
      apply_table("sorted");

      // Golden decks for starts at 10 and 11 cycles after reset.
      do_reset();
      shuffle_timed(10, 0, e);
      build_model(e);
      read_deck();
      check_deck("gold10");
      for (int k = 0; k < 16; k++) d10[k] = buf_a[k];

      do_reset();
      shuffle_timed(11, 0, e);
      build_model(e);
      read_deck();
      check_deck("gold11");
      diff = 0;
      for (int k = 0; k < 16; k++) if (buf_a[k] != d10[k]) diff = 1;
      chk("deck10_vs_11_differs", 32'(diff), 32'd1);

      // Stray start during SWAP is ignored.
      shuffle_timed(3, 8, e);
      build_model(e);
      read_deck();
      check_deck("poke");

      // Held start re-triggers right after DONE/IDLE.
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         chk($sformatf("hold_busy_c%0d", k), 32'(busy),
             32'((k <= 16) || (k >= 19 && k <= 34)));
         chk($sformatf("hold_done_c%0d", k), 32'(done), 32'(k == 17 || k == 35));
         if (k == 35) start = 1'b0;
      end
      chk("hold_ready_end", 32'(ready), 32'd1);

      // Reset in cycle 9 of a shuffle.
      start = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("mid_busy_c%0d", k), 32'(busy), 32'd1);
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("mid_no_done", 32'(ndone), 32'd0);
      chk("mid_ready_low", 32'(ready), 32'd0);
      apply_table("mid_sorted");
      shuffle_timed(2, 0, e);
      build_model(e);
      read_deck();
      check_deck("after_mid");

      // Shuffles at random offsets.
      for (int s = 0; s < 50; s++) begin
         shuffle_timed(int'($urandom_range(0, 20)), 0, e);
         build_model(e);
         read_deck();
         check_deck($sformatf("rnd%0d", s));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
